// File: rtl/grad_spi_arb_pkg.sv
// Shared types and constants for the gradient SPI arbiter.
package grad_spi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam int unsigned CNT_W = 16;

  // Fill bit for the readback delivered when a transfer times out.
  localparam logic ABORT_BIT = 1'b0;

endpackage

// File: rtl/grad_spi_arb.sv
// Two-requester round-robin arbiter in front of a single SPI serialiser, with a
// per-transfer timeout that reports a sticky error.
module grad_spi_arb
  import grad_spi_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned DW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] req0_data_i,
  input  logic          req0_valid_i,
  output logic          req0_ready_o,
  output logic [DW-1:0] req0_rdata_o,
  output logic          req0_rvalid_o,
  input  logic [DW-1:0] req1_data_i,
  input  logic          req1_valid_i,
  output logic          req1_ready_o,
  output logic [DW-1:0] req1_rdata_o,
  output logic          req1_rvalid_o,
  output logic [DW-1:0] ser_data_o,
  output logic          ser_valid_o,
  input  logic          ser_done_i,
  input  logic [DW-1:0] ser_rdata_i,
  input  logic          err_clr_i,
  output logic          err_o,
  output logic          busy_o
);

  state_e             state_q, state_d;
  logic               lp_q, lp_d;
  logic               owner_q, owner_d;
  logic [DW-1:0]      sdata_q, sdata_d;
  logic [DW-1:0]      rd0_q, rd0_d;
  logic [DW-1:0]      rd1_q, rd1_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic               gnt_vld;
  logic               gnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic               timeout;
  logic               err_set;
  logic [DW-1:0]      rd_cap;

  // On a tie the requester that was not served last wins.
  assign gnt_vld = (state_q == ST_IDLE) && (req0_valid_i || req1_valid_i);
  assign gnt     = (req0_valid_i && req1_valid_i) ? ~lp_q : ~req0_valid_i;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout = (cnt_inc == CNT_W'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    lp_d    = lp_q;
    owner_d = owner_q;
    sdata_d = sdata_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    rd_cap  = '0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          sdata_d = gnt ? req1_data_i : req0_data_i;
          owner_d = gnt;
          lp_d    = gnt;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_inc;
        // A done arriving on the timeout cycle still counts as success.
        if (ser_done_i || timeout) begin
          rd_cap  = ser_done_i ? ser_rdata_i : {DW{ABORT_BIT}};
          err_set = ~ser_done_i;
          if (owner_q) rd1_d = rd_cap;
          else         rd0_d = rd_cap;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (err_set)        err_d = 1'b1;
    else if (err_clr_i) err_d = 1'b0;
    else                err_d = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lp_q    <= 1'b1;
      owner_q <= 1'b0;
      sdata_q <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lp_q    <= lp_d;
      owner_q <= owner_d;
      sdata_q <= sdata_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign req0_ready_o  = gnt_vld && !gnt;
  assign req1_ready_o  = gnt_vld &&  gnt;
  assign req0_rvalid_o = (state_q == ST_RESP) && !owner_q;
  assign req1_rvalid_o = (state_q == ST_RESP) &&  owner_q;
  assign req0_rdata_o  = rd0_q;
  assign req1_rdata_o  = rd1_q;
  assign ser_data_o    = sdata_q;
  assign ser_valid_o   = (state_q == ST_ISSUE);
  assign err_o         = err_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_grad_spi_arb.sv
// Randomised and directed checks of grad_spi_arb against a transaction-schedule model.
module tb_grad_spi_arb;

  localparam int unsigned DW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] req0_data_i, req1_data_i, ser_rdata_i;
  logic          req0_valid_i, req1_valid_i, ser_done_i, err_clr_i;
  logic          req0_ready_o, req1_ready_o, req0_rvalid_o, req1_rvalid_o;
  logic [DW-1:0] req0_rdata_o, req1_rdata_o, ser_data_o;
  logic          ser_valid_o, err_o, busy_o;

  logic [DW-1:0] b_data0, b_data1, b_srd;
  logic          b_valid0, b_valid1, b_done, b_clr;
  logic          b_ready0, b_ready1, b_rvalid0, b_rvalid1;
  logic [DW-1:0] b_rdata0, b_rdata1, b_sdata;
  logic          b_svalid, b_err, b_busy;

  always #5 clk = ~clk;

  grad_spi_arb #(.TIMEOUT(TO), .DW(DW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_data_i(req0_data_i), .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_rdata_o(req0_rdata_o), .req0_rvalid_o(req0_rvalid_o),
    .req1_data_i(req1_data_i), .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_rdata_o(req1_rdata_o), .req1_rvalid_o(req1_rvalid_o),
    .ser_data_o(ser_data_o), .ser_valid_o(ser_valid_o), .ser_done_i(ser_done_i),
    .ser_rdata_i(ser_rdata_i), .err_clr_i(err_clr_i), .err_o(err_o), .busy_o(busy_o)
  );

  grad_spi_arb #(.DW(DW)) u_big (
    .clk(clk), .rst_n(rst_n),
    .req0_data_i(b_data0), .req0_valid_i(b_valid0), .req0_ready_o(b_ready0),
    .req0_rdata_o(b_rdata0), .req0_rvalid_o(b_rvalid0),
    .req1_data_i(b_data1), .req1_valid_i(b_valid1), .req1_ready_o(b_ready1),
    .req1_rdata_o(b_rdata1), .req1_rvalid_o(b_rvalid1),
    .ser_data_o(b_sdata), .ser_valid_o(b_svalid), .ser_done_i(b_done),
    .ser_rdata_i(b_srd), .err_clr_i(b_clr), .err_o(b_err), .busy_o(b_busy)
  );

  int tests = 0;
  int fails = 0;

  // Model: each transfer is a schedule of absolute cycles (issue, done, resp).
  int            cyc, issue_c, resp_c, done_c;
  logic          lp, owner, err_m, to_flag;
  logic [DW-1:0] exp_sd, pend_rd, exp_rd0, exp_rd1;
  int            next_k;
  logic [DW-1:0] next_rd;
  int            gq[$];

  task automatic model_reset();
    issue_c = -10; resp_c = -10; done_c = -10;
    lp = 1'b1; owner = 1'b0; err_m = 1'b0; to_flag = 1'b0;
    exp_sd = '0; pend_rd = '0; exp_rd0 = '0; exp_rd1 = '0;
  endtask

  task automatic step(input logic v0, input logic v1, input logic [DW-1:0] d0,
                      input logic [DW-1:0] d1, input logic clr, input logic spur);
    logic busy_e, hs, g, waitwin, e_rv0, e_rv1;
    @(negedge clk);
    busy_e  = (cyc >= issue_c) && (cyc <= resp_c);
    waitwin = (cyc > issue_c) && (cyc < resp_c);
    hs = 1'b0;
    g  = 1'b0;
    if (!busy_e && (v0 || v1)) begin
      hs = 1'b1;
      g  = (v0 && v1) ? !lp : !v0;
    end
    if (cyc == resp_c) begin
      if (owner) exp_rd1 = pend_rd;
      else       exp_rd0 = pend_rd;
    end
    e_rv0 = (cyc == resp_c) && !owner;
    e_rv1 = (cyc == resp_c) &&  owner;
    req0_valid_i = v0; req0_data_i = d0;
    req1_valid_i = v1; req1_data_i = d1;
    err_clr_i    = clr;
    ser_done_i   = (cyc == done_c) || (spur && !waitwin);
    ser_rdata_i  = (cyc == done_c) ? pend_rd : DW'($urandom);
    #1;
    tests++; if (req0_ready_o !== (hs && !g)) begin fails++; $display("FAIL ready0 cyc=%0d got=%b exp=%b", cyc, req0_ready_o, hs && !g); end
    tests++; if (req1_ready_o !== (hs && g)) begin fails++; $display("FAIL ready1 cyc=%0d got=%b exp=%b", cyc, req1_ready_o, hs && g); end
    tests++; if (ser_valid_o !== (cyc == issue_c)) begin fails++; $display("FAIL ser_valid cyc=%0d got=%b exp=%b", cyc, ser_valid_o, cyc == issue_c); end
    tests++; if (busy_o !== busy_e) begin fails++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy_o, busy_e); end
    tests++; if (req0_rvalid_o !== e_rv0) begin fails++; $display("FAIL rvalid0 cyc=%0d got=%b exp=%b", cyc, req0_rvalid_o, e_rv0); end
    tests++; if (req1_rvalid_o !== e_rv1) begin fails++; $display("FAIL rvalid1 cyc=%0d got=%b exp=%b", cyc, req1_rvalid_o, e_rv1); end
    tests++; if (req0_rdata_o !== exp_rd0) begin fails++; $display("FAIL rdata0 cyc=%0d got=%h exp=%h", cyc, req0_rdata_o, exp_rd0); end
    tests++; if (req1_rdata_o !== exp_rd1) begin fails++; $display("FAIL rdata1 cyc=%0d got=%h exp=%h", cyc, req1_rdata_o, exp_rd1); end
    tests++; if (ser_data_o !== exp_sd) begin fails++; $display("FAIL ser_data cyc=%0d got=%h exp=%h", cyc, ser_data_o, exp_sd); end
    tests++; if (err_o !== err_m) begin fails++; $display("FAIL err cyc=%0d got=%b exp=%b", cyc, err_o, err_m); end
    if (to_flag && (cyc == resp_c - 1)) err_m = 1'b1;
    else if (clr)                      err_m = 1'b0;
    if (hs) begin
      exp_sd  = g ? d1 : d0;
      owner   = g;
      lp      = g;
      gq.push_back(int'(g));
      issue_c = cyc + 1;
      if (next_k <= TO) begin
        done_c  = issue_c + next_k;
        resp_c  = done_c + 1;
        pend_rd = next_rd;
        to_flag = 1'b0;
      end else begin
        done_c  = -10;
        resp_c  = issue_c + TO + 1;
        pend_rd = '0;
        to_flag = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    tests++; if ({req0_ready_o, req1_ready_o, req0_rvalid_o, req1_rvalid_o, ser_valid_o, err_o, busy_o} !== 7'b0) begin
      fails++; $display("FAIL reset_flags got=%b exp=0", {req0_ready_o, req1_ready_o, req0_rvalid_o, req1_rvalid_o, ser_valid_o, err_o, busy_o}); end
    tests++; if ({ser_data_o, req0_rdata_o, req1_rdata_o} !== '0) begin
      fails++; $display("FAIL reset_data got=%h/%h/%h exp=0", ser_data_o, req0_rdata_o, req1_rdata_o); end
  endtask

  task automatic test_tie();
    int exp_order[4] = '{0, 1, 0, 1};
    gq.delete();
    next_k = 2; next_rd = 32'h1111_2222;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, DW'($urandom), DW'($urandom), 1'b0, 1'b0);
    tests++; if (gq.size() != 4) begin fails++; $display("FAIL tie_count got=%0d exp=4", gq.size()); end
    for (int i = 0; i < 4 && i < gq.size(); i++) begin
      tests++; if (gq[i] != exp_order[i]) begin fails++; $display("FAIL tie_order idx=%0d got=%0d exp=%0d", i, gq[i], exp_order[i]); end
    end
    idle(2);
  endtask

  task automatic test_timeout();
    int t_iss = -1, t_rv = -1;
    next_k = 99;
    step(1'b1, 1'b0, 32'hDEAD_BEEF, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      if (ser_valid_o === 1'b1) t_iss = i;
      if (req0_rvalid_o === 1'b1) begin
        t_rv = i;
        tests++; if (req0_rdata_o !== '0) begin fails++; $display("FAIL timeout_rdata got=%h exp=0", req0_rdata_o); end
      end
    end
    tests++; if (t_iss < 0 || t_rv - t_iss != 16) begin fails++; $display("FAIL timeout_latency got=%0d exp=16", t_rv - t_iss); end
    idle(3);
    tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL err_sticky got=%b exp=1", err_o); end
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    idle(1);
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL err_clear got=%b exp=0", err_o); end
  endtask

  task automatic test_coincide();
    logic [DW-1:0] rd;
    int seen = 0;
    rd = DW'($urandom) | 32'h1;
    next_k = TO; next_rd = rd;
    step(1'b0, 1'b1, '0, 32'h0BAD_CAFE, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      if (req1_rvalid_o === 1'b1) begin
        seen++;
        tests++; if (req1_rdata_o !== rd) begin fails++; $display("FAIL coincide_rdata got=%h exp=%h", req1_rdata_o, rd); end
      end
    end
    tests++; if (seen != 1) begin fails++; $display("FAIL coincide_rvalid got=%0d exp=1", seen); end
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL coincide_err got=%b exp=0", err_o); end
  endtask

  task automatic test_reset_wait();
    int seen = 0;
    next_k = 99;
    step(1'b0, 1'b1, '0, 32'h5555_AAAA, 1'b0, 1'b0);
    idle(5);
    @(negedge clk);
    req0_valid_i = 1'b0; req1_valid_i = 1'b0; ser_done_i = 1'b0; err_clr_i = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL rst_wait_busy got=%b exp=0", busy_o); end
    tests++; if ({req0_rvalid_o, req1_rvalid_o} !== 2'b00) begin fails++; $display("FAIL rst_wait_rvalid got=%b exp=00", {req0_rvalid_o, req1_rvalid_o}); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    next_k = 4; next_rd = 32'h7777_0001;
    step(1'b0, 1'b1, '0, 32'h1234_5678, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      if (req1_rvalid_o === 1'b1) seen++;
    end
    tests++; if (seen != 1) begin fails++; $display("FAIL rst_wait_next got=%0d exp=1", seen); end
  endtask

  task automatic test_spurious();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      tests++; if (busy_o !== 1'b0 || req0_rvalid_o !== 1'b0 || req1_rvalid_o !== 1'b0) begin
        fails++; $display("FAIL spurious got=%b%b%b exp=000", busy_o, req0_rvalid_o, req1_rvalid_o); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      next_k  = int'($urandom_range(1, 20));
      next_rd = DW'($urandom);
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), DW'($urandom), DW'($urandom),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
    end
    next_k = 3;
    idle(25);
  endtask

  task automatic test_single();
    int sv_cnt = 0, rv0_cnt = 0, rv1_cnt = 0, rv_at = -1;
    @(negedge clk);
    b_valid0 = 1'b1; b_data0 = 32'h0012_3456;
    #1;
    tests++; if (b_ready0 !== 1'b1) begin fails++; $display("FAIL single_ready got=%b exp=1", b_ready0); end
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      b_valid0 = 1'b0;
      b_done   = (c == 41);
      b_srd    = (c == 41) ? 32'hA5A5_0000 : DW'($urandom);
      #1;
      if (b_svalid === 1'b1) begin
        sv_cnt++;
        tests++; if (c != 1 || b_sdata !== 32'h0012_3456) begin fails++; $display("FAIL single_issue got=c%0d/%h exp=c1/00123456", c, b_sdata); end
      end
      if (b_rvalid0 === 1'b1) begin rv0_cnt++; rv_at = c; end
      if (b_rvalid1 === 1'b1) rv1_cnt++;
    end
    b_done = 1'b0;
    tests++; if (sv_cnt != 1) begin fails++; $display("FAIL single_svalid got=%0d exp=1", sv_cnt); end
    tests++; if (rv0_cnt != 1 || rv_at != 42) begin fails++; $display("FAIL single_rvalid0 got=%0d@%0d exp=1@42", rv0_cnt, rv_at); end
    tests++; if (b_rdata0 !== 32'hA5A5_0000) begin fails++; $display("FAIL single_rdata got=%h exp=a5a50000", b_rdata0); end
    tests++; if (rv1_cnt != 0) begin fails++; $display("FAIL single_rvalid1 got=%0d exp=0", rv1_cnt); end
  endtask

  initial begin
    req0_data_i = '0; req1_data_i = '0; ser_rdata_i = '0;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0; ser_done_i = 1'b0; err_clr_i = 1'b0;
    b_data0 = '0; b_data1 = '0; b_srd = '0;
    b_valid0 = 1'b0; b_valid1 = 1'b0; b_done = 1'b0; b_clr = 1'b0;
    cyc = 0; next_k = 3; next_rd = '0;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_tie();
    test_timeout();
    test_coincide();
    test_spurious();
    test_reset_wait();
    test_random();
    test_single();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/grad_spi_arb.md
GRAD_SPI_ARB -- requirements
Module: grad_spi_arb

Interface
REQ-001 Parameter TIMEOUT, default 1023: max cycles in WAIT before abort; legal range 1..65535.
REQ-002 Parameter DW, default 32: SPI word width, shared by requests and readback.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0_data_i  input  DW  requester-0 word (sequencer path).
REQ-006 req0_valid_i  input  1  requester-0 word valid.
REQ-007 req0_ready_o  output  1  requester-0 word accepted this cycle.
REQ-008 req0_rdata_o  output  DW  readback for requester 0.
REQ-009 req0_rvalid_o  output  1  one-cycle readback-valid pulse for requester 0.
REQ-010 req1_data_i, req1_valid_i, req1_ready_o, req1_rdata_o, req1_rvalid_o: same directions, widths and meaning as REQ-005..009, for requester 1 (register path).
REQ-011 ser_data_o  output  DW  word to the FHDO SPI serialiser.
REQ-012 ser_valid_o  output  1  one-cycle start pulse to the serialiser.
REQ-013 ser_done_i  input  1  serialiser finished; ser_rdata_i valid this cycle.
REQ-014 ser_rdata_i  input  DW  SDI word shifted in during the transfer.
REQ-015 err_clr_i  input  1  clears err_o.
REQ-016 err_o  output  1  sticky flag: a transfer timed out.
REQ-017 busy_o  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, RESP; reset state IDLE.
REQ-019 IDLE: grant computed combinationally from the valids and the last-grant pointer lp; a single valid requester wins; when both are valid, the requester != lp wins.
REQ-020 reqN_ready_o = (state==IDLE) and (grant==N), combinational; at most one ready high per cycle.
REQ-021 On handshake (valid&ready): latch data into ser_data_o, store owner and set lp=owner, go to ISSUE.
REQ-022 ISSUE: ser_valid_o=1 for exactly one cycle; clear the timeout counter; go to WAIT.
REQ-023 WAIT: counter increments each cycle; ser_done_i=1 -> capture ser_rdata_i, go to RESP.
REQ-024 WAIT: counter==TIMEOUT without done -> set err_o, captured rdata = all zeros, go to RESP.
REQ-025 ser_done_i arriving in the same cycle the counter reaches TIMEOUT: done wins; err_o stays unchanged.
REQ-026 RESP: owner's rvalid=1 for exactly one cycle with rdata; the other requester's rvalid stays 0; go to IDLE.
REQ-027 reqN_rdata_o holds the last value delivered to requester N until N's next RESP.
REQ-028 Latency: handshake cycle T -> ser_valid_o at T+1; done at cycle D -> rvalid at D+1; back-to-back grant possible at D+2.
REQ-029 ser_done_i outside WAIT is ignored.
REQ-030 ser_data_o is stable from ISSUE through RESP.
REQ-031 err_o: set-dominant when set and err_clr_i coincide; otherwise cleared by err_clr_i.
REQ-032 Counter width is 16 bits; it saturates and never wraps.

Reset
REQ-033 On rst_n low, mid-transfer included, the FSM returns to IDLE with no rvalid issued.
REQ-034 Reset values: lp=1 (requester 0 wins first tie), all *_data_o/rdata_o=0, all valid/ready/rvalid=0, err_o=0, busy_o=0.
REQ-035 Deassertion is synchronised externally; the block needs no extra reset cycles.

Structure
REQ-036 The state enumeration and the timeout-abort readback constant (zero) go in the shared flocra package.
REQ-037 A single module; no sub-module.

Verification
REQ-038 Single request: req0 0x0012_3456, done after 40 cycles with rdata 0xA5A5_0000 -> ser_valid_o one pulse, req0_rvalid_o one pulse with 0xA5A5_0000, req1_rvalid_o 0.
REQ-039 Tie: both valid in IDLE after reset -> req0 granted first, then req1; continuously asserted valids alternate 0,1,0,1.
REQ-040 Timeout: TIMEOUT=15, done never arrives -> rvalid 16 cycles after ISSUE with rdata 0, err_o=1 until err_clr_i pulse.
REQ-041 Done and timeout coincide at count 15 -> rdata = ser_rdata_i, err_o stays 0.
REQ-042 rst_n low during WAIT -> no rvalid, busy_o=0, the next request proceeds normally.
REQ-043 Spurious ser_done_i in IDLE -> no rvalid, no state change.
